// File: rtl/alu_ops_pkg.sv
// Shared ALU operation codes and execute-unit state encoding.
// Imported by the ALU controller and the execute stage.
package alu_ops_pkg;

    localparam int unsigned ALU_CODE_W = 4;

    localparam logic [ALU_CODE_W-1:0] ALU_ADD = 4'd0;
    localparam logic [ALU_CODE_W-1:0] ALU_SUB = 4'd1;
    localparam logic [ALU_CODE_W-1:0] ALU_AND = 4'd2;
    localparam logic [ALU_CODE_W-1:0] ALU_OR  = 4'd3;
    localparam logic [ALU_CODE_W-1:0] ALU_NOR = 4'd4;
    localparam logic [ALU_CODE_W-1:0] ALU_XOR = 4'd5;
    localparam logic [ALU_CODE_W-1:0] ALU_SLL = 4'd6;
    localparam logic [ALU_CODE_W-1:0] ALU_SRL = 4'd7;
    localparam logic [ALU_CODE_W-1:0] ALU_MUL = 4'd8;
    localparam logic [ALU_CODE_W-1:0] ALU_SLT = 4'd9;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } exec_state_e;

endpackage

// File: rtl/seq_multiplier.sv
// Iterative radix-2 shift-add multiplier; one partial product per clock, WIDTH iterations.
// product/last are combinational views of the next accumulator so the caller can latch on the final edge.
module seq_multiplier #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] product,
    output logic             last
);

    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             active_q;

    // Accumulator value after the current iteration; final on the edge where last is high.
    always_comb begin
        product = acc_q + (mplier_q[0] ? mcand_q : '0);
        last    = active_q && (cnt_q == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else if (load) begin
            mcand_q  <= a;
            mplier_q <= b;
            acc_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b1;
        end else if (active_q) begin
            acc_q    <= product;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CNT_W'(1);
            if (last) begin
                active_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle ops with 1-cycle registered latency, mul via the
// iterative multiplier behind a Start/Busy/Done handshake.
module alu_exec_unit
    import alu_ops_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  Start,
    input  logic [ALU_CODE_W-1:0] ALUControl,
    input  logic [WIDTH-1:0]      A,
    input  logic [WIDTH-1:0]      B,
    output logic                  Busy,
    output logic                  Done,
    output logic [WIDTH-1:0]      ALUResult,
    output logic                  Zero
);

    localparam int unsigned SHAMT_W = $clog2(WIDTH);

    exec_state_e      state_q;
    exec_state_e      state_d;
    logic             mul_load_c;
    logic             single_go_c;
    logic [WIDTH-1:0] single_res_c;
    logic [WIDTH-1:0] mul_product;
    logic             mul_last;
    logic [SHAMT_W-1:0] shamt;

    assign shamt = A[SHAMT_W-1:0];

    seq_multiplier #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_mul (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .load    (mul_load_c),
        .a       (A),
        .b       (B),
        .product (mul_product),
        .last    (mul_last)
    );

    // Single-cycle datapath; unused codes produce zero.
    always_comb begin
        single_res_c = '0;
        unique case (ALUControl)
            ALU_ADD: single_res_c = A + B;
            ALU_SUB: single_res_c = A - B;
            ALU_AND: single_res_c = A & B;
            ALU_OR:  single_res_c = A | B;
            ALU_NOR: single_res_c = ~(A | B);
            ALU_XOR: single_res_c = A ^ B;
            ALU_SLL: single_res_c = B << shamt;
            ALU_SRL: single_res_c = B >> shamt;
            ALU_SLT: single_res_c = WIDTH'($signed(A) < $signed(B));
            default: single_res_c = '0;
        endcase
    end

    // Start is only honoured in IDLE, which is what makes it ignored while Busy.
    always_comb begin
        state_d     = state_q;
        mul_load_c  = 1'b0;
        single_go_c = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    if (ALUControl == ALU_MUL) begin
                        mul_load_c = 1'b1;
                        state_d    = ST_MUL;
                    end else begin
                        single_go_c = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                if (mul_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Busy      <= 1'b0;
            Done      <= 1'b0;
            ALUResult <= '0;
            Zero      <= 1'b1;
        end else begin
            Done <= 1'b0;
            if (single_go_c) begin
                Done      <= 1'b1;
                ALUResult <= single_res_c;
                Zero      <= (single_res_c == '0);
            end else if (mul_load_c) begin
                Busy <= 1'b1;
            end else if (state_q == ST_MUL && mul_last) begin
                Busy      <= 1'b0;
                Done      <= 1'b1;
                ALUResult <= mul_product;
                Zero      <= (mul_product == '0);
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed-vector bench for alu_exec_unit with hand-computed expectations.
module tb_alu_exec_unit;

    logic        Clk;
    logic        Rst_n;
    logic        Start;
    logic [3:0]  ALUControl;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic        Done;
    logic [31:0] ALUResult;
    logic        Zero;

    int n_cmp = 0;
    int n_err = 0;

    alu_exec_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .Start      (Start),
        .ALUControl (ALUControl),
        .A          (A),
        .B          (B),
        .Busy       (Busy),
        .Done       (Done),
        .ALUResult  (ALUResult),
        .Zero       (Zero)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic single(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string tag);
        Start = 1'b1; ALUControl = code; A = a; B = b;
        tick();
        Start = 1'b0;
        check({tag, "_done"}, 32'(Done), 32'd1);
        check({tag, "_res"}, ALUResult, exp);
        check({tag, "_zero"}, 32'(Zero), 32'(exp == 32'd0));
        check({tag, "_busy"}, 32'(Busy), 32'd0);
    endtask

    // Issue a mul, optionally pulsing a stray Start at edge number inj; count edges to Done.
    task automatic do_mul(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp,
                          input int inj, input string tag);
        int edges;
        int busy_cnt;
        int extra_done;
        Start = 1'b1; ALUControl = 4'd8; A = a; B = b;
        tick();
        edges = 1;
        busy_cnt = Busy ? 1 : 0;
        Start = 1'b0; A = 32'h0; B = 32'h0;
        while (!Done && edges < 40) begin
            if (edges == inj) begin
                Start = 1'b1; ALUControl = 4'd0; A = 32'h1; B = 32'h1;
            end else begin
                Start = 1'b0;
            end
            tick();
            edges++;
            if (Busy) busy_cnt++;
        end
        Start = 1'b0;
        check({tag, "_latency"}, 32'(edges), 32'd33);
        check({tag, "_busycycles"}, 32'(busy_cnt), 32'd32);
        check({tag, "_res"}, ALUResult, exp);
        check({tag, "_zero"}, 32'(Zero), 32'(exp == 32'd0));
        check({tag, "_busy_end"}, 32'(Busy), 32'd0);
        extra_done = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (Done) extra_done++;
        end
        check({tag, "_extra_done"}, 32'(extra_done), 32'd0);
        check({tag, "_hold"}, ALUResult, exp);
    endtask

    initial begin
        Rst_n = 1'b0; Start = 1'b1; ALUControl = 4'd0; A = 32'h1; B = 32'h1;
        repeat (3) tick();
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_res", ALUResult, 32'd0);
        check("rst_zero", 32'(Zero), 32'd1);
        Start = 1'b0;
        Rst_n = 1'b1;
        tick();
        check("idle_no_done", 32'(Done), 32'd0);

        single(4'd1, 32'd5, 32'd5, 32'd0, "sub");
        tick();
        check("sub_pulse", 32'(Done), 32'd0);
        single(4'd9, 32'hFFFF_FFFF, 32'd1, 32'd1, "slt");
        single(4'd6, 32'd4, 32'h1, 32'h10, "sll");
        single(4'd7, 32'd1, 32'h8000_0000, 32'h4000_0000, "srl");
        single(4'd5, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'hF00F_F00F, "xor");
        single(4'd12, 32'h1234, 32'h5678, 32'd0, "rsvd");

        // Back-to-back: add, and, nor with Start held.
        Start = 1'b1; A = 32'hF0; B = 32'h3C; ALUControl = 4'd0;
        tick();
        check("b2b_add_done", 32'(Done), 32'd1);
        check("b2b_add_res", ALUResult, 32'h12C);
        ALUControl = 4'd2;
        tick();
        check("b2b_and_done", 32'(Done), 32'd1);
        check("b2b_and_res", ALUResult, 32'h30);
        ALUControl = 4'd4;
        tick();
        check("b2b_nor_done", 32'(Done), 32'd1);
        check("b2b_nor_res", ALUResult, 32'hFFFF_FF03);
        Start = 1'b0;
        tick();
        check("b2b_after_done", 32'(Done), 32'd0);
        check("b2b_hold", ALUResult, 32'hFFFF_FF03);

        do_mul(32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFF9, -1, "mul_neg");
        do_mul(32'h0001_0000, 32'h0001_0000, 32'd0, -1, "mul_wrap");
        do_mul(32'h0000_1234, 32'h0000_5678, 32'h0626_0060, 10, "mul_ignore");

        // Asynchronous reset in the middle of a multiply.
        Start = 1'b1; ALUControl = 4'd8; A = 32'hFFFF_FFFF; B = 32'd7;
        tick();
        Start = 1'b0;
        repeat (15) tick();
        check("midrst_busy_pre", 32'(Busy), 32'd1);
        #2;
        Rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(Busy), 32'd0);
        check("midrst_res", ALUResult, 32'd0);
        check("midrst_zero", 32'(Zero), 32'd1);
        check("midrst_done", 32'(Done), 32'd0);
        tick();
        Rst_n = 1'b1;
        tick();
        check("midrst_quiet", 32'(Done), 32'd0);
        do_mul(32'd3, 32'd4, 32'd12, -1, "mul_after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
